rr_arbiter: RTL
===============

# rr_arbiter

Round-robin arbiter that shares one downstream resource among N requesters. Each cycle in which the resource is free, it chooses the first asserting requester at or after a rotating pointer. That choice is a priority-encode over the rotated request vector. The arbiter then holds the grant until the owner releases it. The block sits in front of any shared datapath consumer and drives both a one-hot grant and an encoded grant index with a valid flag.

## Interface
- N, 8, number of requesters (N ≥ 2)
- MAX_HOLD, 16, maximum grant cycles before forced release; used only when RR_ARB_TIMEOUT_EN is defined (MAX_HOLD ≥ 1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request vector, bit i = requester i
- done  input  1  owner release strobe, sampled only in GRANT
- gnt  output  N  one-hot grant, registered
- gnt_id  output  $clog2(N)  index of granted requester, registered
- gnt_valid  output  1  high while a grant is held
- timeout  output  1  one-cycle pulse on forced release

## Operation
- State machine with two states, IDLE and GRANT. Reset state is IDLE.
- Rotating pointer ptr has width $clog2(N). Reset value is 0.
- **IDLE, req != 0:** pick winner w = the first index i with req[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wraps modulo N). Load gnt=1<<w, gnt_id=w, gnt_valid=1, and go to GRANT.
- **IDLE, req == 0:** stay in IDLE with outputs at zero.
- **GRANT, release condition:** release on `done`=1, or req[gnt_id]=0 (owner withdrew). On release: gnt=0, gnt_valid=0, ptr=(gnt_id+1) mod N, go to IDLE. gnt_id keeps its last value.
- **GRANT, no release:** hold gnt, gnt_id and gnt_valid unchanged. Changes in non-owner requests are ignored.
- `done` in IDLE has no effect.
- gnt is always zero or one-hot, and gnt_valid == (gnt != 0).
- No requester wins twice while another requester has been continuously asserting. Each waiting requester is granted within N-1 grants.

## Timing
- **Reset values:** gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, state IDLE. Asserting rst_n mid-grant clears all of these immediately (asynchronous), with no release pulse.
- **Grant latency:** req sampled at edge k in IDLE; grant visible after edge k.
- **Release latency:** release condition sampled at edge m; gnt cleared after edge m.
- **Minimum gap:** one idle cycle between consecutive grants. The next grant appears after edge m+1 at the earliest.
- **Minimum grant length:** 1 cycle, when `done` is high on the first GRANT cycle.
- **Simultaneous done and timeout:** treated as a normal release with timeout=0.

## Configuration
- Macro RR_ARB_TIMEOUT_EN controls the hold-timeout feature.
- **RR_ARB_TIMEOUT_EN defined:**
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD with no release, the arbiter force-releases exactly as a normal release: gnt=0, ptr advances, state IDLE.
  - timeout pulses 1 for that single cycle.
  - The counter resets to 0 asynchronously.
- **RR_ARB_TIMEOUT_EN undefined:**
  - No counter is built and a grant is held indefinitely.
  - The timeout port remains present and is tied to 0.

## Test plan
- **Reset:** rst_n=0 with req=8'hFF → gnt=0, gnt_id=0, gnt_valid=0, timeout=0. Release rst_n → gnt=8'b00000001, gnt_id=0 after the next edge.
- **Single request:** req=8'b00001000 → after one edge gnt=8'b00001000, gnt_id=3, gnt_valid=1. Pulse done → gnt=0 next edge and ptr=4.
- **Wrap-around:** with ptr=4, req=8'b00000110 → gnt_id=1. Release, then req=8'b00000110 again → gnt_id=2.
- **Fairness:** from reset, req=8'b10000001 held, with done pulsed on every grant → grant sequence id 0, 7, 0, 7, separated by one idle cycle each.
- **Owner withdrawal:** grant id 5 held. Drop req[5] while req[2]=1 → gnt=0 next edge, then gnt_id=2 one edge later, with ptr=6 before that search.
- **Timeout (macro defined, MAX_HOLD=4):** req=8'b00010000 held, done=0 → gnt_valid high for 4 cycles, timeout=1 for one cycle as gnt clears, then re-grant of id 4. Without the macro, gnt holds for 100+ cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with registered one-hot/encoded grant held until release
// Optional hold timeout is built only when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int IW = $clog2(N);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] ptr;
    logic          win_found;
    logic [IW-1:0] win_id;
    logic          owner_release;
    logic          hold_expire;
    logic [IW-1:0] next_ptr;
    int            idx;

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!win_found && req[IW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IW'(idx);
            end
        end
    end

    assign owner_release = done || !req[gnt_id];
    assign next_ptr      = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt;

    // Counter sits at zero through IDLE, so every grant starts counting from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign hold_expire = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD - 1));
`else
    assign hold_expire = (MAX_HOLD < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (win_found) begin
                    gnt         <= '0;
                    gnt[win_id] <= 1'b1;
                    gnt_id      <= win_id;
                    gnt_valid   <= 1'b1;
                    state       <= GRANT;
                end
            end else begin
                if (owner_release || hold_expire) begin
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    ptr       <= next_ptr;
                    state     <= IDLE;
                    // A normal release on the expiry cycle wins and suppresses the pulse.
                    timeout   <= hold_expire && !owner_release;
                end
            end
        end
    end

endmodule
